// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0]     ZeroWord    = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] PcStep      = 32'd4;
    localparam logic [InstAddrBus-1:0] AlignMask   = 32'hFFFF_FFFC;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;

    // Source of the next fetch address, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        PcSelFlush  = 2'd0,
        PcSelHold   = 2'd1,
        PcSelBranch = 2'd2,
        PcSelInc    = 2'd3
    } pcSel_e;

    // Word-align an address: instruction fetches never use the low two bits.
    function automatic logic [InstAddrBus-1:0] alignAddr(input logic [InstAddrBus-1:0] addr);
        return addr & AlignMask;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control inputs, ROM bus and IF/ID outputs.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [5:0]             stall;
    logic                   flush;
    logic [InstAddrBus-1:0] new_pc;
    logic                   branch_flag_i;
    logic [InstAddrBus-1:0] branch_target_address_i;
    logic [InstAddrBus-1:0] pc;
    logic                   ce;
    logic [InstBus-1:0]     inst_i;
    logic [InstAddrBus-1:0] id_pc;
    logic [InstBus-1:0]     id_inst;

    // The fetch unit drives the ROM address and the ID-facing registers.
    modport master (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i, inst_i,
        output pc, ce, id_pc, id_inst
    );

    // The surrounding pipeline / ROM sees the opposite directions.
    modport slave (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i, inst_i,
        input  pc, ce, id_pc, id_inst
    );

endinterface

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline register: carries the fetched pc/instruction into decode.
module if_id
    import fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_stallIf,
    input  logic                   i_stallId,
    input  logic [InstAddrBus-1:0] i_ifPc,
    input  logic [InstBus-1:0]     i_ifInst,
    output logic [InstAddrBus-1:0] o_idPc,
    output logic [InstBus-1:0]     o_idInst
);

    logic [InstAddrBus-1:0] r_idPc;
    logic [InstBus-1:0]     r_idInst;

    // Flush clears, a fetch stall with decode running inserts a bubble,
    // a running fetch captures, and a stall of both stages holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idPc   <= ZeroWord;
            r_idInst <= ZeroWord;
        end else if (i_flush) begin
            r_idPc   <= ZeroWord;
            r_idInst <= ZeroWord;
        end else if (i_stallIf == Stop && i_stallId == NoStop) begin
            r_idPc   <= ZeroWord;
            r_idInst <= ZeroWord;
        end else if (i_stallIf == NoStop) begin
            r_idPc   <= i_ifPc;
            r_idInst <= i_ifInst;
        end
    end

    assign o_idPc   = r_idPc;
    assign o_idInst = r_idInst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, ROM chip enable and the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic                   r_ce;
    logic [InstAddrBus-1:0] r_pc;
    logic [InstAddrBus-1:0] w_nextPc;
    logic [InstBus-1:0]     w_ifInst;
    pcSel_e                 w_pcSel;
    logic                   w_unusedStall;

    // The ROM is enabled from the first edge after reset release onwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce <= ChipDisable;
        end else begin
            r_ce <= ChipEnable;
        end
    end

    // Pick the next-pc source: flush beats stall, stall beats branch.
    always_comb begin
        w_pcSel = PcSelInc;
        if (bus.flush) begin
            w_pcSel = PcSelFlush;
        end else if (bus.stall[0] == Stop) begin
            w_pcSel = PcSelHold;
        end else if (bus.branch_flag_i == Branch) begin
            w_pcSel = PcSelBranch;
        end
    end

    // Form the next fetch address; targets are word-aligned, increment wraps.
    always_comb begin
        w_nextPc = r_pc + PcStep;
        case (w_pcSel)
            PcSelFlush:  w_nextPc = alignAddr(bus.new_pc);
            PcSelHold:   w_nextPc = r_pc;
            PcSelBranch: w_nextPc = alignAddr(bus.branch_target_address_i);
            default:     w_nextPc = r_pc + PcStep;
        endcase
    end

    // While the ROM is disabled the pc stays at zero so the first fetch is 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= ZeroWord;
        end else if (r_ce == ChipDisable) begin
            r_pc <= ZeroWord;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    // A disabled ROM returns ZeroWord, so that is what decode gets.
    assign w_ifInst = (r_ce == ChipEnable) ? bus.inst_i : ZeroWord;

    assign bus.pc = r_pc;
    assign bus.ce = r_ce;

    // Stall bits above ID belong to later stages.
    assign w_unusedStall = ^bus.stall[5:3];

    if_id u_ifId (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (bus.flush),
        .i_stallIf (bus.stall[1]),
        .i_stallId (bus.stall[2]),
        .i_ifPc    (r_pc),
        .i_ifInst  (w_ifInst),
        .o_idPc    (bus.id_pc),
        .o_idInst  (bus.id_inst)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a cycle-level reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] idPc;
        logic [31:0] idInst;
    } obs_t;

    obs_t        expQ[$];
    event        sampleReq;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] mPc     = 32'h0;
    logic        mCe     = 1'b0;
    logic [31:0] mIdPc   = 32'h0;
    logic [31:0] mIdInst = 32'h0;

    // ROM contents: word n holds 0x1000_0000 + n.
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // The ROM answers combinationally for whatever address is on the bus.
    always_comb bus.inst_i = romWord(bus.pc);

    task automatic modelReset();
        mPc     = 32'h0;
        mCe     = 1'b0;
        mIdPc   = 32'h0;
        mIdInst = 32'h0;
    endtask

    // One rising edge of the fetch stage, computed from the stage's rules.
    task automatic modelEdge(input logic [5:0] st, input logic fl, input logic [31:0] npc,
                             input logic br, input logic [31:0] tgt);
        logic [31:0] fetchPc;
        logic [31:0] fetchInst;
        logic [31:0] nPc;
        fetchPc   = mCe ? mPc : 32'h0;
        fetchInst = mCe ? romWord(mPc) : 32'h0;
        if (!mCe)        nPc = 32'h0;
        else if (fl)     nPc = {npc[31:2], 2'b00};
        else if (st[0])  nPc = mPc;
        else if (br)     nPc = {tgt[31:2], 2'b00};
        else             nPc = mPc + 32'd4;
        if (fl || (st[1] && !st[2])) begin
            mIdPc   = 32'h0;
            mIdInst = 32'h0;
        end else if (!st[1]) begin
            mIdPc   = fetchPc;
            mIdInst = fetchInst;
        end
        mPc = nPc;
        mCe = 1'b1;
    endtask

    task automatic pushModel();
        obs_t e;
        e.pc     = mPc;
        e.ce     = mCe;
        e.idPc   = mIdPc;
        e.idInst = mIdInst;
        expQ.push_back(e);
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input obs_t e);
        checkField("pc",      bus.pc,             e.pc);
        checkField("ce",      {31'h0, bus.ce},    {31'h0, e.ce});
        checkField("id_pc",   bus.id_pc,          e.idPc);
        checkField("id_inst", bus.id_inst,        e.idInst);
    endtask

    // Drive one cycle at the falling edge, then post the expected result
    // of the following rising edge to the scoreboard.
    task automatic applyStimulus(input logic rstV, input logic [5:0] st, input logic fl,
                                 input logic [31:0] npc, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        rst                         = rstV;
        bus.stall                   = st;
        bus.flush                   = fl;
        bus.new_pc                  = npc;
        bus.branch_flag_i           = br;
        bus.branch_target_address_i = tgt;
        if (!rstV) modelReset();
        else       modelEdge(st, fl, npc, br, tgt);
        @(posedge clk);
        pushModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Reset asserted between edges while stalled must clear outputs at once.
    task automatic midCycleReset();
        @(negedge clk);
        bus.stall = 6'b000011;
        bus.flush = 1'b0;
        bus.branch_flag_i = 1'b0;
        #2;
        rst = 1'b0;
        modelReset();
        pushModel();
        -> sampleReq;
        @(posedge clk);
        pushModel();
    endtask

    // Monitor: after each edge (or an async-reset sample request) compare
    // the DUT against the oldest scoreboard entry.
    initial begin
        forever begin
            @(posedge clk or sampleReq);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Hard stop in case the run never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        bus.stall                   = 6'b0;
        bus.flush                   = 1'b0;
        bus.new_pc                  = 32'h0;
        bus.branch_flag_i           = 1'b0;
        bus.branch_target_address_i = 32'h0;

        #1;
        rst = 1'b0;
        modelReset();
        pushModel();
        -> sampleReq;

        applyStimulus(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Release and free-run up to pc=0x10.
        idle(5);
        // Stall PC and IF for two cycles, then resume.
        applyStimulus(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1);
        // IF stalled with ID running: bubble, pc still advances.
        applyStimulus(1'b1, 6'b000010, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 64 && mPc != 32'h20; i++) idle(1);
        // Branch with unaligned target, then flush racing a branch.
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
        applyStimulus(1'b1, 6'b000111, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0200);
        idle(2);
        // Branch while PC stalled must be ignored.
        applyStimulus(1'b1, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
        idle(1);

        // Wrap-around of the increment.
        applyStimulus(1'b1, 6'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        idle(3);

        // Async reset in the middle of a stalled cycle, then restart.
        applyStimulus(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        midCycleReset();
        applyStimulus(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        rV;
            logic [5:0]  st;
            logic        fl;
            logic        br;
            rV = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            st = {3'($urandom),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0)};
            fl = ($urandom_range(0, 19) == 0);
            br = ($urandom_range(0, 3) == 0);
            applyStimulus(rV, st, fl, $urandom, br, $urandom);
        end

        idle(2);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
